// File: rtl/clk_div_seq.sv
// Divided-clock run/stop sequencer: half-period counter, glitch-free park-low on stop,
// ratio changes latched via valid/ready and applied only at a falling boundary.
module clk_div_seq #(
    parameter int          CNT_W        = 12,
    parameter int unsigned DEFAULT_HALF = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_rise_q, tick_rise_d;
    logic             tick_fall_q, tick_fall_d;
    logic             cfg_err_q, cfg_err_d;

    logic             term;
    logic             xfer;
    logic [CNT_W-1:0] cnt_adv;

    assign term    = (cnt_q == cur_half_q - CNT_W'(1));
    assign cnt_adv = term ? '0 : cnt_q + CNT_W'(1);
    assign xfer    = cfg_valid && !pend_valid_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_half_d   = cur_half_q;
        pend_half_d  = pend_half_q;
        pend_valid_d = pend_valid_q;
        clk_out_d    = clk_out_q;
        tick_rise_d  = 1'b0;
        tick_fall_d  = 1'b0;
        cfg_err_d    = xfer && (cfg_half == '0);

        unique case (state_q)
            IDLE: begin
                clk_out_d = 1'b0;
                cnt_d     = '0;
                if (pend_valid_q) begin
                    cur_half_d   = pend_half_q;
                    pend_valid_d = 1'b0;
                end
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN, STOPPING: begin
                // Stop during a low phase: park immediately, suppress the pending rise.
                if (state_q == RUN && !run && !clk_out_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_adv;
                    if (term) begin
                        clk_out_d   = !clk_out_q;
                        tick_rise_d = !clk_out_q;
                        tick_fall_d = clk_out_q;
                        if (clk_out_q && pend_valid_q) begin
                            cur_half_d   = pend_half_q;
                            pend_valid_d = 1'b0;
                        end
                    end
                    // A stop request lands in STOPPING unless this edge is already the fall.
                    if (state_q == STOPPING || !run) begin
                        state_d = (term && clk_out_q) ? IDLE : STOPPING;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase

        if (xfer && (cfg_half != '0)) begin
            pend_half_d  = cfg_half;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_half_q   <= CNT_W'(DEFAULT_HALF);
            pend_half_q  <= '0;
            pend_valid_q <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_rise_q  <= 1'b0;
            tick_fall_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_half_q   <= cur_half_d;
            pend_half_q  <= pend_half_d;
            pend_valid_q <= pend_valid_d;
            clk_out_q    <= clk_out_d;
            tick_rise_q  <= tick_rise_d;
            tick_fall_q  <= tick_fall_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_ready = !pend_valid_q;
    assign clk_out   = clk_out_q;
    assign tick_rise = tick_rise_q;
    assign tick_fall = tick_fall_q;
    assign busy      = (state_q != IDLE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_seq.sv
// Directed bench for clk_div_seq: reset, divide ratios, ratio change, stop, illegal and max config.
module tb_clk_div_seq;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        cfg_valid;
    logic [11:0] cfg_half;
    logic        cfg_ready;
    logic        clk_out;
    logic        tick_rise;
    logic        tick_fall;
    logic        busy;
    logic        cfg_err;

    int n_assert;
    int n_fail;

    clk_div_seq #(.CNT_W(12), .DEFAULT_HALF(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called right after the edge that sampled run=1 in IDLE (edge k); checks edges k+1..k+n.
    task automatic check_wave(input string tag, input int h, input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk1({tag, "_clk"},  clk_out,   ((i / h) % 2) == 1);
            chk1({tag, "_rise"}, tick_rise, (i % h == 0) && ((i / h) % 2 == 1));
            chk1({tag, "_fall"}, tick_fall, (i % h == 0) && ((i / h) % 2 == 0));
            chk1({tag, "_busy"}, busy,      1'b1);
        end
    endtask

    // Must be called in IDLE: offer, see ready drop, then see IDLE apply it.
    task automatic load_half(input string tag, input logic [11:0] h);
        cfg_valid = 1'b1;
        cfg_half  = h;
        tick();
        cfg_valid = 1'b0;
        chk1({tag, "_rdy_lo"}, cfg_ready, 1'b0);
        tick();
        chk1({tag, "_rdy_hi"}, cfg_ready, 1'b1);
    endtask

    task automatic stop_and_idle(input string tag);
        int k;
        k   = 0;
        run = 1'b0;
        tick();
        while (busy && k < 20) begin
            tick();
            k++;
        end
        chk1({tag, "_stop_busy"}, busy,    1'b0);
        chk1({tag, "_stop_clk"},  clk_out, 1'b0);
    endtask

    logic [11:0] max_cnt;

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;

        // Reset state, before any clock edge
        #3;
        chk1("rst_clk",   clk_out,   1'b0);
        chk1("rst_rise",  tick_rise, 1'b0);
        chk1("rst_fall",  tick_fall, 1'b0);
        chk1("rst_busy",  busy,      1'b0);
        chk1("rst_err",   cfg_err,   1'b0);
        chk1("rst_ready", cfg_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;

        // Default H=1: toggles every cycle from k+1
        run = 1'b1;
        tick();
        chk1("h1_busy0", busy,    1'b1);
        chk1("h1_clk0",  clk_out, 1'b0);
        check_wave("h1", 1, 3);
        // Offer H=7 while high; it must not apply at the rise, then reset discards it
        cfg_valid = 1'b1;
        cfg_half  = 12'd7;
        tick();
        cfg_valid = 1'b0;
        chk1("pend_rdy_lo", cfg_ready, 1'b0);
        chk1("pend_clk_lo", clk_out,   1'b0);
        tick();
        chk1("pend_clk_hi",  clk_out,   1'b1);
        chk1("pend_rdy_lo2", cfg_ready, 1'b0);
        chk1("pend_rise",    tick_rise, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_clk",   clk_out,   1'b0);
        chk1("arst_rise",  tick_rise, 1'b0);
        chk1("arst_busy",  busy,      1'b0);
        chk1("arst_err",   cfg_err,   1'b0);
        chk1("arst_ready", cfg_ready, 1'b1);
        run = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        run   = 1'b1;
        tick();
        check_wave("h1_after_rst", 1, 4);
        stop_and_idle("h1");

        // Basic divide by H=3
        load_half("div3", 12'd3);
        run = 1'b1;
        tick();
        check_wave("div3", 3, 12);
        stop_and_idle("div3");

        // Ratio change 4 -> 2 offered mid-high-phase
        load_half("rc4", 12'd4);
        run = 1'b1;
        tick();
        check_wave("rc4", 4, 5);
        cfg_valid = 1'b1;
        cfg_half  = 12'd2;
        tick();
        chk1("rc_rdy_lo6", cfg_ready, 1'b0);
        cfg_half = 12'd9;
        tick();
        chk1("rc_rdy_lo7", cfg_ready, 1'b0);
        chk1("rc_clk7",    clk_out,   1'b1);
        cfg_valid = 1'b0;
        tick();
        chk1("rc_clk8",  clk_out,   1'b0);
        chk1("rc_fall8", tick_fall, 1'b1);
        chk1("rc_rdy8",  cfg_ready, 1'b1);
        for (int i = 9; i <= 16; i++) begin
            tick();
            chk1("rc_h2_clk",  clk_out,   (((i - 8) / 2) % 2) == 1);
            chk1("rc_h2_rise", tick_rise, (i == 10) || (i == 14));
            chk1("rc_h2_rdy",  cfg_ready, 1'b1);
        end
        stop_and_idle("rc");

        // Graceful stop with H=5; run dropped 2 cycles into high, re-raised while STOPPING
        load_half("gs5", 12'd5);
        run = 1'b1;
        tick();
        check_wave("gs", 5, 6);
        run = 1'b0;
        tick();
        chk1("gs_busy7", busy,    1'b1);
        chk1("gs_clk7",  clk_out, 1'b1);
        run = 1'b1;
        tick();
        chk1("gs_clk8",  clk_out, 1'b1);
        chk1("gs_busy8", busy,    1'b1);
        tick();
        chk1("gs_clk9",  clk_out, 1'b1);
        tick();
        chk1("gs_clk10",  clk_out,   1'b0);
        chk1("gs_busy10", busy,      1'b0);
        chk1("gs_fall10", tick_fall, 1'b1);
        tick();
        chk1("gs_rerun_busy", busy,    1'b1);
        chk1("gs_rerun_clk",  clk_out, 1'b0);
        check_wave("gs_re", 5, 11);
        // Drop run during low phase: IDLE next cycle, no rise
        run = 1'b0;
        tick();
        chk1("gl_busy",  busy,      1'b0);
        chk1("gl_clk",   clk_out,   1'b0);
        chk1("gl_rise",  tick_rise, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("gl_quiet_clk",  clk_out,   1'b0);
            chk1("gl_quiet_rise", tick_rise, 1'b0);
        end

        // Illegal config: cfg_err one pulse, ready stays 1, H stays 5
        cfg_valid = 1'b1;
        cfg_half  = 12'd0;
        tick();
        cfg_valid = 1'b0;
        chk1("bad_err",   cfg_err,   1'b1);
        chk1("bad_rdy",   cfg_ready, 1'b1);
        tick();
        chk1("bad_err_clr", cfg_err,   1'b0);
        chk1("bad_rdy2",    cfg_ready, 1'b1);
        run = 1'b1;
        tick();
        check_wave("bad_h5", 5, 10);
        stop_and_idle("bad");

        // Max half-period 4095
        load_half("max", 12'd4095);
        run     = 1'b1;
        max_cnt = '0;
        tick();
        for (int i = 1; i <= 8191; i++) begin
            tick();
            if (dut.cnt_q > max_cnt) max_cnt = dut.cnt_q;
            if (i == 4094) chk1("max_clk4094", clk_out, 1'b0);
            if (i == 4095) begin
                chk1("max_clk4095",  clk_out,   1'b1);
                chk1("max_rise4095", tick_rise, 1'b1);
            end
            if (i == 8189) chk1("max_clk8189", clk_out, 1'b1);
            if (i == 8190) begin
                chk1("max_clk8190",  clk_out,   1'b0);
                chk1("max_fall8190", tick_fall, 1'b1);
            end
            if (i == 8191) chk1("max_clk8191", clk_out, 1'b0);
        end
        chk32("max_cnt_peak", 32'(max_cnt), 32'd4094);
        stop_and_idle("max");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_seq.md
# clk_div_seq

Run/stop and ratio-change sequencer for the programmable clock-divider datapath. It owns the half-period counter and divided-clock register, and parks the output low on stop without glitches. It accepts new divide ratios through a valid/ready handshake and applies them only at a falling-edge boundary. It sits between the control/register block and every logic block that consumes a divided clock or its enable ticks.

## Interface
- `CNT_W`, 12, width of the counter and half-period fields.
- `DEFAULT_HALF`, 1, half-period in `clk` cycles loaded at reset; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  level request; 1 = generate, 0 = stop gracefully.
- `cfg_valid`  in  1  new half-period offered.
- `cfg_half`  in  CNT_W  requested half-period in `clk` cycles; 0 is illegal.
- `cfg_ready`  out  1  equals `!pend_valid`; a transfer occurs when `cfg_valid && cfg_ready`.
- `clk_out`  out  1  registered divided clock, period 2·H.
- `tick_rise`  out  1  one-cycle pulse, high in the first cycle `clk_out` reads 1.
- `tick_fall`  out  1  one-cycle pulse, high in the first cycle `clk_out` reads 0 after a high phase.
- `busy`  out  1  high when state ≠ IDLE.
- `cfg_err`  out  1  one-cycle pulse, one cycle after a transfer with `cfg_half == 0`.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, STOPPING}
  - `cnt[CNT_W]`
  - `cur_half[CNT_W]`, the active H
  - `pend_half[CNT_W]` and `pend_valid`
  - `clk_out`, ticks, `cfg_err`
- Reset (async, `rst_n` = 0):
  - state IDLE, `cnt` = 0, `cur_half` = DEFAULT_HALF, `pend_valid` = 0
  - `clk_out`, `tick_rise`, `tick_fall`, `cfg_err` = 0
  - hence `cfg_ready` = 1 and `busy` = 0
- Terminal count: `term = (cnt == cur_half-1)`. On `term`: `cnt` ← 0 and `clk_out` toggles. Otherwise `cnt` ← `cnt+1`. Unsigned, no wrap beyond `cur_half-1`.
- IDLE:
  - `clk_out` held 0, `cnt` held 0.
  - If `pend_valid`: `cur_half` ← `pend_half`, `pend_valid` ← 0.
  - If `run` = 1: go to RUN with `cnt` = 0. A pending apply and a `run` in the same cycle both take effect, so the new H governs the first low phase.
- RUN:
  - Counts as above.
  - A falling toggle (`term && clk_out` = 1) with `pend_valid` applies the pending value: `cur_half` ← `pend_half`, `pend_valid` ← 0. The new H governs the low phase that follows.
  - Pending values are never applied at a rising toggle.
- RUN with `run` = 0:
  - If `clk_out` = 0: go to IDLE next cycle with `cnt` ← 0. The truncated low phase causes no glitch.
  - If `clk_out` = 1: go to STOPPING.
- STOPPING:
  - Keeps counting until the falling toggle, then goes to IDLE. The pending-apply rule still holds at that edge.
  - `run` is ignored; it is re-sampled in IDLE.
- Config handshake:
  - On a transfer with `cfg_half` ≠ 0: `pend_half` ← `cfg_half`, `pend_valid` ← 1.
  - On a transfer with `cfg_half` = 0: nothing is stored and `cfg_err` pulses.
  - At most one pending value exists. `cfg_ready` returns to 1 the cycle after the apply.
- Ticks:
  - `tick_rise` ← (`term && !clk_out` in RUN/STOPPING)
  - `tick_fall` ← (`term && clk_out`)
  - Both are registered alongside `clk_out`.

## Timing
- `run` sampled 1 in IDLE at edge k:
  - `clk_out` rises at edge k+H.
  - Falls at k+2H, with period 2H and 50% duty.
  - With H = 1, `clk_out` toggles every cycle starting at k+1.
- Latency of `run` deasserting to `clk_out` = 0 and IDLE:
  - If high: ≤ remaining high phase + 1 cycle.
  - If low: 1 cycle.
- `busy` falls in the same cycle `state` becomes IDLE.
- Config accepted at edge m: `cfg_ready` = 0 from m until the apply edge.
- `cfg_err` is high during cycle m+1 only.
- Reset mid-period: `clk_out` drops to 0 immediately (async), and any pending config is discarded.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-high-phase → `clk_out`, ticks, `busy`, `cfg_err` go to 0 immediately and `cfg_ready` = 1. After release with DEFAULT_HALF = 1 and `run` = 1, `clk_out` toggles every cycle.
- **Basic divide:** `cfg_half` = 3 in IDLE, then `run` = 1 at edge k → rises at k+3, falls at k+6, period 6. `tick_rise` and `tick_fall` are each one cycle wide and coincide with the edges.
- **Ratio change while running:** H = 4 running, offer `cfg_half` = 2 mid-high-phase → `cfg_ready` drops. The high phase completes at 4 cycles, the next low and high phases are 2 cycles each, and `cfg_ready` returns to 1 one cycle after the falling edge. A second offer while not ready is not accepted.
- **Graceful stop:** H = 5, drop `run` 2 cycles into a high phase → STOPPING, the high phase completes its full 5 cycles, then `clk_out` = 0 and `busy` = 0. Drop `run` during a low phase → IDLE next cycle with no extra edge. Reassert `run` during STOPPING → ignored until IDLE.
- **Illegal config:** `cfg_half` = 0 → `cfg_err` pulses once, `cur_half` is unchanged, and `cfg_ready` stays 1.
- **Max value:** `cfg_half` = 4095 (CNT_W = 12) → half-period exactly 4095 cycles, and `cnt` never exceeds 4094.
